decode_stage: RTL

Parametrised instruction-decode stage for the pipelined processor. It contains:
- the register bank, with write-through bypass;
- destination-register selection;
- sign/zero immediate extension;
- load-use hazard detection, which stalls the front end;
- a registered ID/EX pipeline boundary with valid, bubble and flush control.

It sits between the IF/ID register and the execute stage. Its write port is driven by write-back.

---
 rtl/decode_stage_if.sv | 51 +++++
 rtl/decode_stage.sv | 103 ++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Signal bundle between the IF/ID register, execute stage, write-back and the decode stage.
// The master drives the instruction, EX-hazard and write-back inputs; the slave is the decode stage.
interface decode_stage_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int IMM_W      = 6,
  parameter int FUNCT_W    = 3
);
  logic                  in_valid;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic [FUNCT_W-1:0]    funct;
  logic [IMM_W-1:0]      imm;
  logic                  ext_zero;
  logic                  reg_dst;
  logic                  uses_rt;
  logic                  mem_read_in;
  logic                  flush;
  logic                  ex_valid;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;

  logic                  stall;
  logic                  out_valid;
  logic [DATA_W-1:0]     out_rs_data;
  logic [DATA_W-1:0]     out_rt_data;
  logic [DATA_W-1:0]     out_imm;
  logic [REG_ADDR_W-1:0] out_rs;
  logic [REG_ADDR_W-1:0] out_rt;
  logic [REG_ADDR_W-1:0] out_dest;
  logic [FUNCT_W-1:0]    out_funct;
  logic                  out_mem_read;

  modport master (
    output in_valid, rs, rt, rd, funct, imm, ext_zero, reg_dst, uses_rt, mem_read_in, flush,
    output ex_valid, ex_mem_read, ex_dest, wb_we, wb_addr, wb_data,
    input  stall, out_valid, out_rs_data, out_rt_data, out_imm, out_rs, out_rt, out_dest,
    input  out_funct, out_mem_read
  );

  modport slave (
    input  in_valid, rs, rt, rd, funct, imm, ext_zero, reg_dst, uses_rt, mem_read_in, flush,
    input  ex_valid, ex_mem_read, ex_dest, wb_we, wb_addr, wb_data,
    output stall, out_valid, out_rs_data, out_rt_data, out_imm, out_rs, out_rt, out_dest,
    output out_funct, out_mem_read
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction-decode stage: register bank with write-through bypass, immediate extension,
// load-use stall generation and the registered ID/EX boundary.
module decode_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int IMM_W      = 6,
  parameter int FUNCT_W    = 3,
  parameter int ZERO_REG   = 1
) (
  input logic          i_clk,
  input logic          i_rst,
  decode_stage_if.slave bus
);
  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam bit ZR       = (ZERO_REG != 0);

  logic [DATA_W-1:0]     r_regs [NUM_REGS];
  logic                  w_wb_ok;
  logic                  w_dest_nz;
  logic                  w_hazard;
  logic                  w_stall;
  logic [DATA_W-1:0]     w_rs_data;
  logic [DATA_W-1:0]     w_rt_data;
  logic [DATA_W-1:0]     w_imm;
  logic [REG_ADDR_W-1:0] w_dest;

  logic                  r_out_valid;
  logic [DATA_W-1:0]     r_out_rs_data;
  logic [DATA_W-1:0]     r_out_rt_data;
  logic [DATA_W-1:0]     r_out_imm;
  logic [REG_ADDR_W-1:0] r_out_rs;
  logic [REG_ADDR_W-1:0] r_out_rt;
  logic [REG_ADDR_W-1:0] r_out_dest;
  logic [FUNCT_W-1:0]    r_out_funct;
  logic                  r_out_mem_read;

  // A write to the hard-wired zero register is dropped, so it must not bypass either.
  assign w_wb_ok = bus.wb_we & ~(ZR & (bus.wb_addr == '0));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wb_ok) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    w_rs_data = r_regs[bus.rs];
    if (w_wb_ok && (bus.wb_addr == bus.rs)) w_rs_data = bus.wb_data;
    if (ZR && (bus.rs == '0)) w_rs_data = '0;
    w_rt_data = r_regs[bus.rt];
    if (w_wb_ok && (bus.wb_addr == bus.rt)) w_rt_data = bus.wb_data;
    if (ZR && (bus.rt == '0)) w_rt_data = '0;
  end

  assign w_dest = bus.reg_dst ? bus.rd : bus.rt;
  assign w_imm  = bus.ext_zero ? {{(DATA_W-IMM_W){1'b0}}, bus.imm}
                               : {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};

  assign w_dest_nz = ZR ? (bus.ex_dest != '0) : 1'b1;
  assign w_hazard  = bus.in_valid & bus.ex_valid & bus.ex_mem_read & w_dest_nz &
                     ((bus.ex_dest == bus.rs) | (bus.uses_rt & (bus.ex_dest == bus.rt)));
  // Reset gates the stall so the front end is released the moment reset asserts.
  assign w_stall   = w_hazard & ~bus.flush & ~i_rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid    <= 1'b0;
      r_out_rs_data  <= '0;
      r_out_rt_data  <= '0;
      r_out_imm      <= '0;
      r_out_rs       <= '0;
      r_out_rt       <= '0;
      r_out_dest     <= '0;
      r_out_funct    <= '0;
      r_out_mem_read <= 1'b0;
    end else if (bus.flush || w_stall) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid    <= bus.in_valid;
      r_out_rs_data  <= w_rs_data;
      r_out_rt_data  <= w_rt_data;
      r_out_imm      <= w_imm;
      r_out_rs       <= bus.rs;
      r_out_rt       <= bus.rt;
      r_out_dest     <= w_dest;
      r_out_funct    <= bus.funct;
      r_out_mem_read <= bus.mem_read_in;
    end
  end

  assign bus.stall        = w_stall;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_rs_data  = r_out_rs_data;
  assign bus.out_rt_data  = r_out_rt_data;
  assign bus.out_imm      = r_out_imm;
  assign bus.out_rs       = r_out_rs;
  assign bus.out_rt       = r_out_rt;
  assign bus.out_dest     = r_out_dest;
  assign bus.out_funct    = r_out_funct;
  assign bus.out_mem_read = r_out_mem_read;
endmodule
